// File: rtl/reorder_buffer.sv
// Reorder buffer: tracks in-flight instructions in program order and retires
// completed ones from the head, one per cycle, returning the old physical register.
module reorder_buffer #(
  parameter int PREG_WIDTH = 7,
  parameter int ROB_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dispatch_valid,
  input  logic [ROB_WIDTH-1:0]  dispatch_rob_tag,
  input  logic                  dispatch_reg_write,
  input  logic [PREG_WIDTH-1:0] dispatch_old_prd,
  input  logic [PREG_WIDTH-1:0] dispatch_prd,
  output logic                  rob_ready,
  input  logic                  complete_valid,
  input  logic [ROB_WIDTH-1:0]  complete_rob_tag,
  input  logic                  flush_valid,
  input  logic [ROB_WIDTH-1:0]  flush_rob_tag,
  output logic                  retire_valid,
  output logic [ROB_WIDTH-1:0]  retire_rob_tag,
  output logic                  commit_en,
  output logic [PREG_WIDTH-1:0] commit_old_preg,
  output logic [PREG_WIDTH-1:0] commit_prd
);

  localparam int DEPTH = 2 ** ROB_WIDTH;
  localparam logic [ROB_WIDTH:0] FULL = (ROB_WIDTH + 1)'(DEPTH);

  logic [ROB_WIDTH-1:0]  head_q, head_d, tail_q, tail_d;
  logic [ROB_WIDTH:0]    count_q, count_d;
  logic [DEPTH-1:0]      valid_q, valid_d, done_q, done_d, rw_q, rw_d;
  logic [PREG_WIDTH-1:0] old_prd_q [DEPTH];
  logic [PREG_WIDTH-1:0] old_prd_d [DEPTH];
  logic [PREG_WIDTH-1:0] prd_q [DEPTH];
  logic [PREG_WIDTH-1:0] prd_d [DEPTH];
  logic                  retire, do_dispatch;
  logic [ROB_WIDTH-1:0]  flush_off, ent_off;

  assign rob_ready   = (count_q != FULL);
  assign retire      = valid_q[head_q] & done_q[head_q];
  assign do_dispatch = dispatch_valid & rob_ready & ~flush_valid;

  assign retire_valid    = retire;
  assign retire_rob_tag  = retire ? head_q : '0;
  assign commit_en       = retire & rw_q[head_q];
  assign commit_old_preg = retire ? old_prd_q[head_q] : '0;
  assign commit_prd      = retire ? prd_q[head_q] : '0;

  always_comb begin
    valid_d   = valid_q;
    done_d    = done_q;
    rw_d      = rw_q;
    old_prd_d = old_prd_q;
    prd_d     = prd_q;
    head_d    = head_q;
    tail_d    = tail_q;
    ent_off   = '0;
    flush_off = flush_rob_tag - head_q;
    count_d   = count_q + (ROB_WIDTH + 1)'(do_dispatch) - (ROB_WIDTH + 1)'(retire);

    if (complete_valid && valid_q[complete_rob_tag]) begin
      done_d[complete_rob_tag] = 1'b1;
    end

    if (do_dispatch) begin
      valid_d[tail_q]   = 1'b1;
      done_d[tail_q]    = 1'b0;
      rw_d[tail_q]      = dispatch_reg_write;
      old_prd_d[tail_q] = dispatch_old_prd;
      prd_d[tail_q]     = dispatch_prd;
      tail_d            = tail_q + ROB_WIDTH'(1);
    end

    // Age is measured as distance from head, so wrap-around needs no special case.
    if (flush_valid) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_off = ROB_WIDTH'(i) - head_q;
        if (ent_off > flush_off) begin
          valid_d[i] = 1'b0;
          done_d[i]  = 1'b0;
        end
      end
      tail_d  = flush_rob_tag + ROB_WIDTH'(1);
      count_d = {1'b0, flush_off} + (ROB_WIDTH + 1)'(1) - (ROB_WIDTH + 1)'(retire);
    end

    if (retire) begin
      valid_d[head_q] = 1'b0;
      done_d[head_q]  = 1'b0;
      head_d          = head_q + ROB_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // Payload is only observed through valid entries, so it needs no reset.
  always_ff @(posedge clk) begin
    rw_q      <= rw_d;
    old_prd_q <= old_prd_d;
    prd_q     <= prd_d;
  end

  a_dispatch_tag: assert property (@(posedge clk) disable iff (reset)
    (dispatch_valid && rob_ready && !flush_valid) |-> (dispatch_rob_tag == tail_q));

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: queue-based program-order model feeds a scoreboard
// of expected retirements; a monitor compares every cycle's retire outputs.
module tb_reorder_buffer;
  localparam int PW = 7;
  localparam int RW = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          dispatch_valid, dispatch_reg_write;
  logic [RW-1:0] dispatch_rob_tag;
  logic [PW-1:0] dispatch_old_prd, dispatch_prd;
  logic          rob_ready;
  logic          complete_valid;
  logic [RW-1:0] complete_rob_tag;
  logic          flush_valid;
  logic [RW-1:0] flush_rob_tag;
  logic          retire_valid;
  logic [RW-1:0] retire_rob_tag;
  logic          commit_en;
  logic [PW-1:0] commit_old_preg, commit_prd;

  reorder_buffer #(.PREG_WIDTH(PW), .ROB_WIDTH(RW)) dut (
    .clk(clk), .reset(reset),
    .dispatch_valid(dispatch_valid), .dispatch_rob_tag(dispatch_rob_tag),
    .dispatch_reg_write(dispatch_reg_write), .dispatch_old_prd(dispatch_old_prd),
    .dispatch_prd(dispatch_prd), .rob_ready(rob_ready),
    .complete_valid(complete_valid), .complete_rob_tag(complete_rob_tag),
    .flush_valid(flush_valid), .flush_rob_tag(flush_rob_tag),
    .retire_valid(retire_valid), .retire_rob_tag(retire_rob_tag),
    .commit_en(commit_en), .commit_old_preg(commit_old_preg), .commit_prd(commit_prd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [RW-1:0] tag;
    logic          rw;
    logic [PW-1:0] old;
    logic [PW-1:0] prd;
    logic          done;
  } ent_t;

  typedef struct {
    int            cyc;
    logic [RW-1:0] tag;
    logic          en;
    logic [PW-1:0] old;
    logic [PW-1:0] prd;
  } exp_t;

  ent_t          mq[$];
  exp_t          eq[$];
  logic [RW-1:0] m_tail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive_idle();
    dispatch_valid = 1'b0; dispatch_reg_write = 1'b0; dispatch_rob_tag = '0;
    dispatch_old_prd = '0; dispatch_prd = '0;
    complete_valid = 1'b0; complete_rob_tag = '0;
    flush_valid = 1'b0; flush_rob_tag = '0;
  endtask

  // One cycle: check readiness, predict this cycle's retirement, drive inputs, advance model.
  task automatic step(input logic dv, input logic rw, input logic [PW-1:0] old,
                      input logic [PW-1:0] prd, input logic cv, input logic [RW-1:0] ctag,
                      input logic fv, input logic [RW-1:0] ftag);
    bit ready, ret;
    int pos;
    @(negedge clk);
    ready = (mq.size() != DEPTH);
    chk("rob_ready", 32'(rob_ready), 32'(ready));
    ret = (mq.size() > 0) && mq[0].done;
    if (ret) eq.push_back('{cyc, mq[0].tag, mq[0].rw, mq[0].old, mq[0].prd});
    dispatch_valid = dv; dispatch_rob_tag = m_tail; dispatch_reg_write = rw;
    dispatch_old_prd = old; dispatch_prd = prd;
    complete_valid = cv; complete_rob_tag = ctag;
    flush_valid = fv; flush_rob_tag = ftag;
    if (cv) foreach (mq[i]) if (mq[i].tag == ctag) mq[i].done = 1'b1;
    if (fv) begin
      pos = -1;
      foreach (mq[i]) if (mq[i].tag == ftag) pos = i;
      if (pos >= 0) while (mq.size() > pos + 1) void'(mq.pop_back());
      m_tail = ftag + 1;
    end else if (dv && ready) begin
      mq.push_back('{m_tail, rw, old, prd, 1'b0});
      m_tail++;
    end
    if (ret) void'(mq.pop_front());
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, '0, '0, 0, '0, 0, '0);
  endtask

  task automatic disp(input logic [PW-1:0] old, input logic [PW-1:0] prd);
    step(1, 1, old, prd, 0, '0, 0, '0);
  endtask

  task automatic comp(input logic [RW-1:0] t);
    step(0, 0, '0, '0, 1, t, 0, '0);
  endtask

  task automatic do_reset(input int hold);
    @(negedge clk);
    chk("pending_before_reset", 32'(eq.size()), 0);
    eq.delete();
    reset = 1'b1;
    drive_idle();
    #1;
    chk("reset_retire_valid", 32'(retire_valid), 0);
    chk("reset_commit_en", 32'(commit_en), 0);
    chk("reset_data_outputs", {13'd0, retire_rob_tag, commit_old_preg, commit_prd}, 0);
    chk("reset_rob_ready", 32'(rob_ready), 1);
    mq.delete();
    m_tail = '0;
    repeat (hold) @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: pops an expected retirement whenever the DUT retires.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (retire_valid) begin
        if (eq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_retire: got tag %0h, required no retire (cycle %0d)",
                   retire_rob_tag, cyc);
        end else begin
          e = eq.pop_front();
          chk("retire_cycle", cyc, e.cyc);
          chk("retire_rob_tag", 32'(retire_rob_tag), 32'(e.tag));
          chk("commit_en", 32'(commit_en), 32'(e.en));
          chk("commit_old_preg", 32'(commit_old_preg), 32'(e.old));
          chk("commit_prd", 32'(commit_prd), 32'(e.prd));
        end
      end else begin
        chk("idle_outputs", {13'd0, retire_rob_tag, commit_old_preg, commit_prd, commit_en}, 0);
        if (eq.size() > 0 && eq[0].cyc <= cyc) begin
          e = eq.pop_front();
          chk("retire_valid", 0, 1);
        end
      end
    end
  end

  initial begin
    bit dv, cv, fv;
    logic [RW-1:0] ctag, ftag;
    int guard;
    reset = 1'b1;
    drive_idle();
    m_tail = '0;
    do_reset(2);

    // Fill all 16 entries, then a 17th dispatch must be dropped.
    for (int i = 0; i < 16; i++) disp(PW'(32 + i), PW'(64 + i));
    disp(7'd99, 7'd99);
    chk("full_rob_ready", 32'(rob_ready), 0);
    // Completion of head retires next cycle and frees a slot the cycle after.
    comp(4'd0);
    idle(2);
    chk("ready_after_retire", 32'(rob_ready), 1);

    // Out-of-order completion held behind a pending head.
    do_reset(1);
    for (int i = 0; i < 4; i++) disp(PW'(10 + i), PW'(20 + i));
    comp(4'd2);
    comp(4'd1);
    idle(3);
    comp(4'd0);
    idle(5);

    // Flush at tag 2 with a simultaneous completion of squashed tag 4.
    do_reset(1);
    for (int i = 0; i < 6; i++) disp(PW'(40 + i), PW'(50 + i));
    step(0, 0, '0, '0, 1, 4'd4, 1, 4'd2);
    disp(7'd77, 7'd78);
    comp(4'd4);
    for (int i = 0; i < 4; i++) comp(RW'(i));
    idle(4);

    // Walk head to 15, then dispatch wrapping to tag 0 while 15 retires.
    do_reset(1);
    for (int i = 0; i < 15; i++) disp(PW'(i), PW'(100 + i));
    for (int i = 0; i < 15; i++) comp(RW'(i));
    idle(3);
    disp(7'd15, 7'd115);
    comp(4'd15);
    disp(7'd16, 7'd116);
    comp(4'd0);
    idle(3);

    // Reset while 8 entries are in flight and the head is done.
    do_reset(1);
    for (int i = 0; i < 8; i++) disp(PW'(60 + i), PW'(70 + i));
    comp(4'd0);
    do_reset(2);
    idle(5);

    // Randomized traffic with wrap-around, flushes and spurious completions.
    for (int n = 0; n < 3000; n++) begin
      dv = ($urandom_range(0, 99) < 60);
      cv = ($urandom_range(0, 99) < 55);
      if (mq.size() > 0 && $urandom_range(0, 9) < 8)
        ctag = mq[$urandom_range(0, mq.size() - 1)].tag;
      else
        ctag = RW'($urandom);
      fv = (mq.size() > 0) && ($urandom_range(0, 99) < 4);
      ftag = (mq.size() > 0) ? mq[$urandom_range(0, mq.size() - 1)].tag : '0;
      step(dv, 1'($urandom), PW'($urandom), PW'($urandom), cv, ctag, fv, ftag);
    end

    guard = 0;
    while (mq.size() > 0 && mq[0].done && guard < 40) begin
      idle(1);
      guard++;
    end
    @(negedge clk);
    #2;
    chk("scoreboard_drained", 32'(eq.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter PREG_WIDTH, default 7, physical register index width.
REQ-002 SHALL have parameter ROB_WIDTH, default 4, tag width; depth DEPTH = 2**ROB_WIDTH (16).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port dispatch_valid  input  1  instruction allocated by rename this cycle.
REQ-006 SHALL have port dispatch_rob_tag  input  ROB_WIDTH  tag assigned by rename.
REQ-007 SHALL have port dispatch_reg_write  input  1  instruction allocates a new physical destination.
REQ-008 SHALL have port dispatch_old_prd  input  PREG_WIDTH  previous mapping of rd, freed at retire.
REQ-009 SHALL have port dispatch_prd  input  PREG_WIDTH  new physical destination.
REQ-010 SHALL have port rob_ready  output  1  at least one free entry.
REQ-011 SHALL have port complete_valid  input  1  execution finished for complete_rob_tag.
REQ-012 SHALL have port complete_rob_tag  input  ROB_WIDTH  tag of the finished instruction.
REQ-013 SHALL have port flush_valid  input  1  branch mispredict; squash entries younger than flush_rob_tag.
REQ-014 SHALL have port flush_rob_tag  input  ROB_WIDTH  tag of the mispredicted branch.
REQ-015 SHALL have port retire_valid  output  1  head instruction retires this cycle.
REQ-016 SHALL have port retire_rob_tag  output  ROB_WIDTH  tag of the retiring entry.
REQ-017 SHALL have port commit_en  output  1  retiring entry had reg_write; free commit_old_preg.
REQ-018 SHALL have port commit_old_preg  output  PREG_WIDTH  physical register returned to the free list.
REQ-019 SHALL have port commit_prd  output  PREG_WIDTH  retiring destination, for architectural map update.

Function
REQ-020 SHALL be a circular buffer: head/tail pointers of ROB_WIDTH bits, count of ROB_WIDTH+1 bits, per-entry valid, done, reg_write, old_prd, prd.
REQ-021 SHALL drive rob_ready = (count != DEPTH), from registered count only; no same-cycle bypass from retire.
REQ-022 SHALL, on dispatch_valid && rob_ready, write the entry at tail (valid=1, done=0), advance tail mod DEPTH, and increment count.
REQ-023 SHALL ignore dispatch_valid when rob_ready=0 and flag nothing (rename is responsible for stalling).
REQ-024 SHALL treat dispatch_rob_tag != tail as a protocol error: write at tail regardless (tag is informational, for checker assertion).
REQ-025 SHALL, on complete_valid for a valid entry, set done=1 at the next edge; completion of an invalid entry SHALL be ignored.
REQ-026 SHALL retire combinationally when entry[head].valid && entry[head].done: retire_valid=1, retire_rob_tag=head, commit_prd/commit_old_preg from entry, commit_en = entry reg_write.
REQ-027 SHALL retire at most one entry per cycle; on retire, clear valid, advance head mod DEPTH, decrement count.
REQ-028 SHALL hold commit_en=0, retire_valid=0 and commit_old_preg/commit_prd/retire_rob_tag=0 when not retiring.
REQ-029 Done set in cycle N for head SHALL produce retire in cycle N+1 (completion-to-retire latency 1).
REQ-030 SHALL, on flush_valid, invalidate all entries strictly younger than flush_rob_tag, set tail = flush_rob_tag+1 mod DEPTH, count = ((flush_rob_tag - head) mod DEPTH) + 1 minus 1 if retiring this cycle.
REQ-031 Flush and dispatch same cycle: dispatch SHALL be dropped.
REQ-032 Flush and complete same cycle for a squashed tag: flush SHALL win (entry stays invalid).
REQ-033 Flush and retire of an older head same cycle: retire SHALL proceed normally.
REQ-034 Dispatch and retire same cycle: count SHALL be unchanged; both pointers advance.
REQ-035 Pointer wrap-around from DEPTH-1 to 0 SHALL be seamless for dispatch, retire and flush.

Reset
REQ-036 Assertion of reset SHALL immediately clear head, tail, count and all valid/done bits, including mid-operation.
REQ-037 During and after reset: rob_ready=1, retire_valid=0, commit_en=0, all data outputs 0.

Verification
REQ-038 Reset, dispatch tags 0..15 (reg_write=1, old_prd=32+i) -> rob_ready=0 after 16th; 17th dispatch dropped; count=16.
REQ-039 Complete tag 0 in cycle N -> cycle N+1 retire_valid=1, retire_rob_tag=0, commit_en=1, commit_old_preg=32; rob_ready=1 in N+2.
REQ-040 Complete tags 2,1 out of order with tag 0 pending -> no retire; complete 0 -> retires 0,1,2 in three consecutive cycles.
REQ-041 Entries 0..5 valid, flush_rob_tag=2 with simultaneous complete tag 4 -> tail=3, count=3, tag 4 never retires; next dispatch lands at tag 3.
REQ-042 Head=15, dispatch wraps to tag 0, retire 15 same cycle -> count unchanged, head=0.
REQ-043 Reset asserted with 8 entries in flight, done set on head -> outputs 0 immediately, rob_ready=1, no retire after release.
